// File: rtl/randomizer_pkg.sv
// Shared constants and types for the WiMAX PRBS randomizer (generator 1 + x^14 + x^15).
package randomizer_pkg;

  localparam int unsigned LFSR_W = 15;
  localparam int unsigned TAP_A  = 14;
  localparam int unsigned TAP_B  = 13;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t DEFAULT_IV = 15'b100101010000000;

endpackage

// File: rtl/randomizer_lfsr.sv
// 15-stage Fibonacci LFSR: loadable seed, step enable, feedback bit out.
// Macro RANDOMIZER_DEFAULT_IV_EN selects DEFAULT_IV as the reset state instead of zero.
module randomizer_lfsr
  import randomizer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  lfsr_t load_value,
  input  logic  step,
  output logic  fb
);

`ifdef RANDOMIZER_DEFAULT_IV_EN
  localparam lfsr_t RESET_STATE = DEFAULT_IV;
`else
  localparam lfsr_t RESET_STATE = '0;
`endif

  lfsr_t state;

  assign fb = state[TAP_A] ^ state[TAP_B];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else if (load) begin
      state <= load_value;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/randomizer.sv
// Bit-serial PRBS data randomizer: each accepted bit is XORed with the LFSR feedback bit.
// Macro RANDOMIZER_DEFAULT_IV_EN (see randomizer_lfsr) changes only the LFSR reset state.
module randomizer
  import randomizer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_bits,
  input  logic  in_valid,
  output logic  out_bits,
  output logic  out_valid,
  input  lfsr_t rand_iv,
  input  logic  reload
);

  logic fb;
  logic accept;

  // A reload cycle drops any simultaneous input bit, so it must not advance the LFSR.
  assign accept = in_valid & ~reload;

  randomizer_lfsr u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (reload),
    .load_value (rand_iv),
    .step       (accept),
    .fb         (fb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_bits  <= 1'b0;
      out_valid <= 1'b0;
    end else if (reload) begin
      out_bits  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_bits  <= in_bits ^ fb;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_randomizer.sv
// Directed, table-driven bench for randomizer with hand-computed PRBS expectations.
module tb_randomizer;
  import randomizer_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  in_bits = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_bits;
  logic  out_valid;
  lfsr_t rand_iv = '0;
  logic  reload = 1'b0;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    logic  ib;
    logic  iv;
    logic  rl;
    lfsr_t riv;
    logic  eb;
    logic  ev;
  } vec_t;

  vec_t vecs[$];

  // IV 15'h4000 with zero data: 1, thirteen 0s, 1.
  logic [14:0] seq4000;

  randomizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_bits   (in_bits),
    .in_valid  (in_valid),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .rand_iv   (rand_iv),
    .reload    (reload)
  );

  always #5 clk = ~clk;

  task automatic add(input logic ib, input logic iv, input logic rl, input lfsr_t riv,
                     input logic eb, input logic ev);
    vec_t v;
    v.ib = ib; v.iv = iv; v.rl = rl; v.riv = riv; v.eb = eb; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic eb, input logic ev);
    total++;
    if (out_bits === eb && out_valid === ev) begin
      passed++;
    end else begin
      $display("FAIL %s: got out_bits=%b out_valid=%b, expected out_bits=%b out_valid=%b",
               name, out_bits, out_valid, eb, ev);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic cyc(input logic ib, input logic iv, input logic rl, input lfsr_t riv);
    in_bits = ib; in_valid = iv; reload = rl; rand_iv = riv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    seq4000 = 15'b100000000000001;

    // Zero-data stream from IV 4000.
    add(0, 0, 1, 15'h4000, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, '0, seq4000[14-i], 1);
    // All-ones data: complement of the previous stream.
    add(0, 0, 1, 15'h4000, 0, 0);
    for (int i = 0; i < 15; i++) add(1, 1, 0, '0, ~seq4000[14-i], 1);
    // Zero data with a 1-cycle gap after bit 0 and a 3-cycle gap after bit 4; gaps hold out_bits.
    add(0, 0, 1, 15'h4000, 0, 0);
    for (int i = 0; i < 15; i++) begin
      add(0, 1, 0, '0, seq4000[14-i], 1);
      if (i == 0) add(0, 0, 0, 15'h7fff, seq4000[14], 0);
      if (i == 4) for (int g = 0; g < 3; g++) add(1, 0, 0, 15'h1234, seq4000[10], 0);
    end
    // Two bits into a stream, then reload with in_valid high: bit dropped, sequence restarts.
    add(0, 0, 1, 15'h4000, 0, 0);
    add(0, 1, 0, '0, 1, 1);
    add(0, 1, 0, '0, 0, 1);
    add(1, 1, 1, 15'h4000, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, '0, seq4000[14-i], 1);
    // Bit following the 15-bit period start: state 0x4001 gives fb=1.
    add(0, 1, 0, '0, 1, 1);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0);
    reset = 1'b1;
    cyc(0, 0, 0, '0);
    check("idle_after_reset", 1'b0, 1'b0);

`ifndef RANDOMIZER_DEFAULT_IV_EN
    begin
      logic [3:0] lock_data;
      lock_data = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        cyc(lock_data[3-i], 1, 0, '0);
        check($sformatf("lockup_passthru[%0d]", i), lock_data[3-i], 1'b1);
      end
    end
`endif

    foreach (vecs[i]) begin
      cyc(vecs[i].ib, vecs[i].iv, vecs[i].rl, vecs[i].riv);
      check($sformatf("vec[%0d]", i), vecs[i].eb, vecs[i].ev);
    end

    // Mid-stream asynchronous reset, then reload reproduces the sequence from its start.
    cyc(0, 0, 1, 15'h4000);
    cyc(0, 1, 0, '0);
    check("pre_reset_bit", 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clears", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
`ifndef RANDOMIZER_DEFAULT_IV_EN
    cyc(1, 1, 0, '0);
    check("post_reset_lockup", 1'b1, 1'b1);
`endif
    cyc(0, 0, 1, 15'h4000);
    check("post_reset_reload", 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 0, '0);
      check($sformatf("post_reset_seq[%0d]", i), seq4000[14-i], 1'b1);
    end
    cyc(0, 0, 0, '0);
    check("final_idle", seq4000[0], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
